// File: rtl/seg_scan_ctrl_if.sv
// Bundle of the display-update handshake and the digit scan outputs of seg_scan_ctrl.
// master drives the value/request side, slave is the scan controller.
interface seg_scan_ctrl_if;
    logic [15:0] bcd_in;
    logic        load;
    logic        lz_blank;
    logic        ack;
    logic [3:0]  an;
    logic [3:0]  digit;
    logic        frame;

    modport master (
        output bcd_in, load, lz_blank,
        input  ack, an, digit, frame
    );

    modport slave (
        input  bcd_in, load, lz_blank,
        output ack, an, digit, frame
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller: prescaled slot scanning with an
// anti-ghost blank phase, frame-aligned display updates and leading-zero blanking.
module seg_scan_ctrl #(
    parameter int DIV       = 16,
    parameter int BLANK_CYC = 2
) (
    input  logic           mclk,
    input  logic           reset,
    seg_scan_ctrl_if.slave bus
);

    localparam int             PW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]  P_LAST = PW'(DIV - 1);
    localparam logic [PW:0]    BLK    = (PW + 1)'(BLANK_CYC);

    logic [PW-1:0] p;
    logic [1:0]    s;
    logic [15:0]   disp;
    logic          ack_q;
    logic          frame_cyc;
    logic          show;
    logic [3:0]    lead;
    logic [3:0]    an_c;
    logic [3:0]    digit_c;

    assign frame_cyc = (p == P_LAST) && (s == 2'd3);

    // p + 1 > BLANK_CYC is p >= BLANK_CYC without a constant-zero unsigned compare
    assign show = ({1'b0, p} + (PW + 1)'(1)) > BLK;

    // Prescaler, slot counter and display register; disp only moves on a frame cycle
    always_ff @(posedge mclk) begin
        if (reset) begin
            p     <= '0;
            s     <= 2'd0;
            disp  <= 16'h0000;
            ack_q <= 1'b0;
        end else begin
            if (p == P_LAST) begin
                p <= '0;
                s <= s + 2'd1;
            end else begin
                p <= p + PW'(1);
            end
            if (frame_cyc && bus.load) begin
                disp <= bus.bcd_in;
            end
            ack_q <= frame_cyc && bus.load;
        end
    end

    // lead[i]: nibbles 3..i are all zero, so digit i is a leading zero
    assign lead[3] = (disp[15:12] == 4'h0);
    assign lead[2] = lead[3] && (disp[11:8] == 4'h0);
    assign lead[1] = lead[2] && (disp[7:4]  == 4'h0);
    assign lead[0] = 1'b0;

    always_comb begin
        an_c    = 4'hF;
        digit_c = 4'h0;
        case (s)
            2'd0:    digit_c = disp[3:0];
            2'd1:    digit_c = disp[7:4];
            2'd2:    digit_c = disp[11:8];
            default: digit_c = disp[15:12];
        endcase
        if (show && !(bus.lz_blank && lead[s])) begin
            an_c[s] = 1'b0;
        end
    end

    assign bus.an    = an_c;
    assign bus.digit = digit_c;
    assign bus.frame = frame_cyc;
    assign bus.ack   = ack_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: a DIV=8/BLANK_CYC=2 instance against a scoreboard model and
// a DIV=4/BLANK_CYC=0 instance free-running alongside it.
module tb_seg_scan_ctrl;

    logic mclk;
    logic reset;

    seg_scan_ctrl_if b1 ();
    seg_scan_ctrl_if b2 ();

    seg_scan_ctrl #(.DIV(8), .BLANK_CYC(2)) dut1 (.mclk(mclk), .reset(reset), .bus(b1));
    seg_scan_ctrl #(.DIV(4), .BLANK_CYC(0)) dut2 (.mclk(mclk), .reset(reset), .bus(b2));

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    // reference state for dut1 (cycle index within the 32-cycle frame) and dut2
    int          m_cyc  = 0;
    logic [15:0] m_disp = 16'h0;
    logic        m_ack  = 1'b0;
    int          k2     = 0;

    logic [9:0] sb[$];

    typedef struct {
        int         n;
        logic       load;
        logic       lz;
        logic [3:0] an;
        logic       frame;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [9:0] model_out(int cyc, logic [15:0] d, logic a, logic z);
        int p, s;
        logic [3:0] an, dg;
        logic lead;
        p    = cyc % 8;
        s    = cyc / 8;
        an   = 4'hF;
        dg   = d[4*s +: 4];
        lead = (s != 0);
        for (int i = 1; i < 4; i++)
            if (i >= s && d[4*i +: 4] != 4'h0) lead = 1'b0;
        if (p >= 2 && !(z && lead)) an[s] = 1'b0;
        return {a, (p == 7 && s == 3), an, dg};
    endfunction

    task automatic tick(input logic r, input logic l, input logic [15:0] b, input logic z);
        logic [9:0] e;
        logic [3:0] a2;
        int p, s;
        reset       = r;
        b1.load     = l;
        b1.bcd_in   = b;
        b1.lz_blank = z;
        if (r) begin
            m_cyc = 0; m_disp = 16'h0; m_ack = 1'b0; k2 = 0;
        end else begin
            p     = m_cyc % 8;
            s     = m_cyc / 8;
            m_ack = (p == 7) && (s == 3) && l;
            if (m_ack) m_disp = b;
            m_cyc = (m_cyc + 1) % 32;
            k2    = (k2 + 1) % 16;
        end
        sb.push_back(model_out(m_cyc, m_disp, m_ack, z));
        @(posedge mclk);
        @(negedge mclk);
        e = sb.pop_front();
        chk("dut1_outputs", {b1.ack, b1.frame, b1.an, b1.digit}, e);
        a2 = ~(4'b0001 << (k2 / 4));
        chk("dut2_outputs", {b2.frame, b2.an, b2.digit}, {(k2 == 15), a2, 4'h0});
    endtask

    task automatic run(input int n, input logic l, input logic [15:0] b, input logic z);
        for (int i = 0; i < n; i++) tick(1'b0, l, b, z);
    endtask

    // hold load until the ack comes back, then release it
    task automatic load_value(input logic [15:0] v, input logic z);
        int n;
        n = 0;
        do begin
            tick(1'b0, 1'b1, v, z);
            n++;
        end while (b1.ack !== 1'b1 && n < 64);
        if (b1.ack !== 1'b1) chk("load_ack_timeout", n, 32);
    endtask

    initial begin
        int n;
        int acks;
        logic [3:0] en;

        tbl[0] = '{1, 1'b0, 1'b0, 4'b1111, 1'b0};
        tbl[1] = '{6, 1'b0, 1'b0, 4'b1110, 1'b0};
        tbl[2] = '{2, 1'b0, 1'b0, 4'b1111, 1'b0};
        tbl[3] = '{6, 1'b0, 1'b0, 4'b1101, 1'b0};
        tbl[4] = '{2, 1'b0, 1'b0, 4'b1111, 1'b0};
        tbl[5] = '{6, 1'b0, 1'b0, 4'b1011, 1'b0};
        tbl[6] = '{2, 1'b0, 1'b0, 4'b1111, 1'b0};
        tbl[7] = '{5, 1'b0, 1'b0, 4'b0111, 1'b0};
        tbl[8] = '{1, 1'b0, 1'b0, 4'b0111, 1'b1};
        tbl[9] = '{1, 1'b0, 1'b0, 4'b1111, 1'b0};

        reset        = 1'b1;
        b1.load      = 1'b0;
        b1.bcd_in    = 16'h0;
        b1.lz_blank  = 1'b0;
        b2.load      = 1'b0;
        b2.bcd_in    = 16'h0;
        b2.lz_blank  = 1'b0;

        // reset held with a pending load: nothing latched, no ack
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 16'h9999, 1'b0);
        chk("reset_an", b1.an, 4'b1111);
        chk("reset_digit", b1.digit, 4'h0);

        // free-run frame pattern from hard-coded expectations
        for (int i = 0; i < 10; i++)
            for (int j = 0; j < tbl[i].n; j++) begin
                tick(1'b0, tbl[i].load, 16'h0, tbl[i].lz);
                chk("freerun_an", b1.an, tbl[i].an);
                chk("freerun_frame", b1.frame, tbl[i].frame);
                chk("freerun_ack", b1.ack, 1'b0);
                chk("div4_no_blank", (b2.an == 4'b1111), 1'b0);
            end

        // load raised in slot 1 latches only on the frame cycle
        run(8, 1'b0, 16'h0, 1'b0);
        n = 0;
        do begin
            tick(1'b0, 1'b1, 16'h1234, 1'b0);
            n++;
        end while (b1.ack !== 1'b1 && n < 40);
        chk("load_ack_latency", n, 24);
        chk("slot0_digit", b1.digit, 4'h4);
        for (int s = 1; s < 4; s++) begin
            run(8, 1'b0, 16'h0, 1'b0);
            chk("slot_digit", b1.digit, 4 - s);
        end

        // leading-zero blanking
        load_value(16'h0050, 1'b1);
        en = 4'b0000;
        for (int i = 0; i < 32; i++) begin
            tick(1'b0, 1'b0, 16'h0, 1'b1);
            en |= ~b1.an;
            if (b1.an[1] == 1'b0) chk("lz_slot1_digit", b1.digit, 4'h5);
        end
        chk("lz_enables_0050", en, 4'b0011);
        run(4, 1'b0, 16'h0, 1'b0);
        run(4, 1'b0, 16'h0, 1'b1);
        load_value(16'h0000, 1'b1);
        en = 4'b0000;
        for (int i = 0; i < 32; i++) begin
            tick(1'b0, 1'b0, 16'h0, 1'b1);
            en |= ~b1.an;
        end
        chk("lz_enables_0000", en, 4'b0001);

        // reset in slot 2 while load is high
        load_value(16'h4321, 1'b0);
        n = 0;
        while (m_cyc != 18 && n < 64) begin
            tick(1'b0, 1'b0, 16'h0, 1'b0);
            n++;
        end
        tick(1'b0, 1'b1, 16'hABCD, 1'b0);
        tick(1'b1, 1'b1, 16'hABCD, 1'b0);
        chk("midreset_an", b1.an, 4'b1111);
        chk("midreset_digit", b1.digit, 4'h0);
        chk("midreset_ack", b1.ack, 1'b0);
        n = 0;
        do begin
            tick(1'b0, 1'b1, 16'h5678, 1'b0);
            n++;
        end while (b1.ack !== 1'b1 && n < 40);
        chk("post_reset_ack_latency", n, 32);
        chk("post_reset_digit", b1.digit, 4'h8);

        // continuous load with changing data: one ack per frame
        acks = 0;
        for (int i = 0; i < 96; i++) begin
            tick(1'b0, 1'b1, 16'($urandom), 1'b0);
            if (b1.ack === 1'b1) acks++;
        end
        chk("continuous_ack_count", acks, 3);
        run(8, 1'b0, 16'h0, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 The block SHALL have parameter DIV, default 16: mclk cycles per digit slot; legal range 4..65535.
REQ-002 The block SHALL have parameter BLANK_CYC, default 2: anti-ghost blank cycles at the start of each slot; legal range 0..DIV-1.
REQ-003 The block SHALL have port mclk  in  1  single system clock; all logic on its rising edge.
REQ-004 The block SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 The block SHALL have port bcd_in  in  16  candidate display value, 4 BCD nibbles, [15:12] = most significant digit 3.
REQ-006 The block SHALL have port load  in  1  update request for bcd_in; held high until ack.
REQ-007 The block SHALL have port lz_blank  in  1  leading-zero blanking enable.
REQ-008 The block SHALL have port ack  out  1  one-cycle pulse confirming that bcd_in was latched.
REQ-009 The block SHALL have port an  out  4  active-low digit enables; bit i drives digit i.
REQ-010 The block SHALL have port digit  out  4  BCD nibble of the currently scanned digit, feeding the segment decoder.
REQ-011 The block SHALL have port frame  out  1  one-cycle pulse on the last cycle of each 4-digit frame.

Function
REQ-012 The block SHALL hold registered state: prescaler p (0..DIV-1), slot s (0..3), display register disp[15:0], and ack; an, digit and frame decode from these with no further pipeline stage.
REQ-013 p SHALL increment every cycle and wrap DIV-1 -> 0; s SHALL increment when p = DIV-1 and wrap 3 -> 0.
REQ-014 Slot phases SHALL be: BLANK while p < BLANK_CYC, with an = 4'b1111; SHOW while p >= BLANK_CYC, with an bit s low and all other bits high.
REQ-015 digit SHALL equal disp[4s+3:4s] in both phases; nibbles > 9 SHALL pass through unmodified.
REQ-016 frame SHALL be 1 exactly when p = DIV-1 and s = 3, giving one pulse per 4*DIV cycles.
REQ-017 If load = 1 on the frame cycle, disp SHALL take bcd_in on that edge; otherwise disp SHALL hold, so no torn frames occur.
REQ-018 ack SHALL be 1 for exactly the one cycle after each latch (p = 0, s = 0) and 0 at all other times.
REQ-019 load asserted outside the frame cycle SHALL have no effect until the next frame cycle; load held continuously SHALL latch on every frame cycle, with one ack per frame.
REQ-020 With lz_blank = 1, digit i (i = 3..1) SHALL be blanked (an bit i high for the whole slot) when disp nibbles 3..i are all zero; digit 0 SHALL never be blanked.
REQ-021 lz_blank SHALL be evaluated combinationally against disp, so a change takes effect in the same cycle.
REQ-022 BLANK_CYC = 0 SHALL produce no BLANK phase; the selected digit is then enabled for all DIV cycles of its slot.

Reset
REQ-023 reset = 1 at a rising edge SHALL set p = 0, s = 0, disp = 16'h0000 and ack = 0; outputs then read an = 4'b1111 (BLANK, or digit 0 enabled if BLANK_CYC = 0), digit = 0, frame = 0.
REQ-024 Reset mid-operation SHALL take effect on the next edge regardless of state.
REQ-025 A load pending during reset SHALL be discarded, with no ack issued.
REQ-026 Reset held high SHALL keep all state at reset values.

Verification (DIV = 8, BLANK_CYC = 2 unless stated)
REQ-027 Free-run after reset release, disp = 0, lz_blank = 0 -> an = 1111 for 2 cycles, then 1110 for 6, then 1111 for 2, then 1101 for 6, then 1011, then 0111; frame high every 32nd cycle; ack stays 0.
REQ-028 load = 1 with bcd_in = 16'h1234, raised during slot 1 -> disp unchanged until the frame cycle; ack high for 1 cycle at p = 0, s = 0; next frame's digit sequence is 4, 3, 2, 1 for slots 0..3.
REQ-029 lz_blank = 1, disp = 16'h0050 -> slots 3 and 2 show an = 1111 throughout; slot 1 shows digit 5; slot 0 shows digit 0. With disp = 16'h0000, only an[0] ever goes low.
REQ-030 reset pulsed during slot 2 while load = 1 -> next cycle p = 0, s = 0, an = 1111, disp = 0; no ack until load is seen on a later frame cycle.
REQ-031 load held high while bcd_in changes every cycle -> exactly one ack per 32 cycles; disp equals the bcd_in value present on each frame cycle.
REQ-032 BLANK_CYC = 0, DIV = 4 -> an cycles 1110, 1101, 1011, 0111 for 4 cycles each, with no 1111 cycles.
